// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one 8N1 UART transmitter
// between NUM_REQ byte-stream requesters, with an inter-byte gap and a stall abort.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int GAP_CYCLES  = 434,
    parameter int STALL_LIMIT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 grant_active,
    output logic                 abort
);

    localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
    // GAP holds for GAP_CYCLES clocks, but never less than one.
    localparam logic [GAP_W-1:0]   GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE,
        GAP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    next_ptr;
    logic               last_flag;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STALL_W-1:0] stall_cnt;

    logic               rr_found;
    logic [ID_W-1:0]    rr_pick;
    logic [ID_W-1:0]    rr_idx;
    int                 rr_sum;

    logic               sel_valid;
    logic               sel_last;
    logic [7:0]         sel_data;

    logic               do_grant;
    logic               do_xfer;
    logic               do_abort;
    logic               do_finish;
    logic               gap_load;
    logic               gap_dec;
    logic               stall_inc;

    // First valid requester at or after ptr, wrapping round.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_sum   = 0;
        rr_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_sum = int'(ptr) + k;
            if (rr_sum >= NUM_REQ) begin
                rr_sum = rr_sum - NUM_REQ;
            end
            rr_idx = ID_W'(rr_sum);
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = rr_idx;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[8*i +: 8];
            end
        end
    end

    assign next_ptr = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[grant_id] = sel_valid && !tx_busy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_xfer    = 1'b0;
        do_abort   = 1'b0;
        do_finish  = 1'b0;
        gap_load   = 1'b0;
        gap_dec    = 1'b0;
        stall_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (rr_found) begin
                    do_grant   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (sel_valid && !tx_busy) begin
                    do_xfer    = 1'b1;
                    state_next = WAIT_ACK;
                end else if (!sel_valid) begin
                    if (stall_cnt == STALL_LAST) begin
                        do_abort   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stall_inc = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    gap_load   = 1'b1;
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    if (last_flag) begin
                        do_finish  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = SEND;
                    end
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // tx_start and abort are registered strobes, so each lasts exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            grant_active <= 1'b0;
            abort        <= 1'b0;
            ptr          <= '0;
            last_flag    <= 1'b0;
            gap_cnt      <= '0;
            stall_cnt    <= '0;
        end else begin
            tx_start <= do_xfer;
            abort    <= do_abort;
            if (do_grant) begin
                grant_id     <= rr_pick;
                grant_active <= 1'b1;
                stall_cnt    <= '0;
            end
            if (do_xfer) begin
                tx_data   <= sel_data;
                last_flag <= sel_last;
                stall_cnt <= '0;
            end
            if (stall_inc) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (do_abort || do_finish) begin
                grant_active <= 1'b0;
                ptr          <= next_ptr;
                stall_cnt    <= '0;
            end
            if (gap_load) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_dec) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule
